// File: rtl/vga_timing_gen_if.sv
// Raster/video bundle between the VGA timing generator, the game renderer and the DAC pins.
// master = timing generator side, slave = renderer/monitor side.
interface vga_timing_gen_if;
    logic [9:0] Xpos;
    logic [9:0] Ypos;
    logic       refresh;
    logic       R_in;
    logic       G_in;
    logic       B_in;
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;

    modport master (
        output Xpos, Ypos, refresh, hsync, vsync, de, vga_r, vga_g, vga_b,
        input  R_in, G_in, B_in
    );

    modport slave (
        input  Xpos, Ypos, refresh, hsync, vsync, de, vga_r, vga_g, vga_b,
        output R_in, G_in, B_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with 2-cycle matched sync/colour pipeline and a frame-divided game tick.
// Define VGA_REFRESH_DIV_EN to divide `refresh` by FRAMES_PER_TICK; otherwise it pulses every frame.
module vga_timing_gen #(
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_ACTIVE        = 640,
    parameter int H_FP            = 16,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_ACTIVE        = 480,
    parameter int V_FP            = 10,
    parameter int FRAMES_PER_TICK = 6
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_B   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_E   = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_ACT_B   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_E   = 10'(V_SYNC + V_BP + V_ACTIVE);

    if (FRAMES_PER_TICK < 1 || FRAMES_PER_TICK > 255) begin : g_bad_fpt
        $error("FRAMES_PER_TICK must be in 1..255");
    end

    logic [9:0] x_q, x_d, y_q, y_d;
    // Stage 1 holds sync as active-low pin levels so reset (1) means "not in sync".
    logic       hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
    logic       hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
    logic [2:0] rgb2_q, rgb2_d;
    logic       refresh_q, refresh_d;
    logic       tick;

    always_comb begin
        x_d = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        y_d = y_q;
        if (x_q == H_LAST) y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;

        hs1_d  = ~(x_q < H_SYNC_E);
        vs1_d  = ~(y_q < V_SYNC_E);
        act1_d = (x_q >= H_ACT_B) && (x_q < H_ACT_E) && (y_q >= V_ACT_B) && (y_q < V_ACT_E);

        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        de2_d  = act1_q;
        rgb2_d = {vif.R_in, vif.G_in, vif.B_in} & {3{act1_q}};
    end

    // First front-porch line start: always inside vertical blanking.
    assign tick = (x_q == 10'd0) && (y_q == V_ACT_E);

`ifdef VGA_REFRESH_DIV_EN
    localparam logic [7:0] FPT_LAST = 8'(FRAMES_PER_TICK - 1);
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        fcnt_d    = fcnt_q;
        refresh_d = 1'b0;
        if (tick) begin
            fcnt_d    = (fcnt_q == FPT_LAST) ? 8'd0 : fcnt_q + 8'd1;
            refresh_d = (fcnt_q == FPT_LAST);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) fcnt_q <= 8'd0;
        else        fcnt_q <= fcnt_d;
    end
`else
    always_comb begin
        refresh_d = tick;
    end
`endif

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b1;
            act1_q    <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b1;
            de2_q     <= 1'b0;
            rgb2_q    <= 3'b000;
            refresh_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            act1_q    <= act1_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            de2_q     <= de2_d;
            rgb2_q    <= rgb2_d;
            refresh_q <= refresh_d;
        end
    end

    assign vif.Xpos    = x_q;
    assign vif.Ypos    = y_q;
    assign vif.hsync   = hs2_q;
    assign vif.vsync   = vs2_q;
    assign vif.de      = de2_q;
    assign vif.vga_r   = rgb2_q[2];
    assign vif.vga_g   = rgb2_q[1];
    assign vif.vga_b   = rgb2_q[0];
    assign vif.refresh = refresh_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (17x10, 170 cycles/frame) so whole frames fit a short run.
module tb_vga_timing_gen;
    localparam int HS = 4, HB = 3, HA = 8, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 2;
    localparam int FPT      = 3;
    localparam int HT       = HS + HB + HA + HF;
    localparam int VT       = VS + VB + VA + VF;
    localparam int FRAME    = HT * VT;
    localparam int TICK_OFF = (VS + VB + VA) * HT;
`ifdef VGA_REFRESH_DIV_EN
    localparam int DIV = FPT;
`else
    localparam int DIV = 1;
`endif

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    vga_timing_gen_if vif();

    vga_timing_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .FRAMES_PER_TICK(FPT)
    ) dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .vif     (vif)
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int passed = 0;
    int n = 0;
    bit [2:0] rgb_h [int];

    typedef struct {
        int         n;
        logic [9:0] x, y;
        logic       hs, vs, de;
    } vec_t;
    vec_t tbl [14];

    // {Xpos, Ypos, hsync, vsync, de, r, g, b, refresh}
    function automatic logic [26:0] pins();
        return {vif.Xpos, vif.Ypos, vif.hsync, vif.vsync, vif.de,
                vif.vga_r, vif.vga_g, vif.vga_b, vif.refresh};
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s n=%0d actual=%h expected=%h", name, n, act, exp);
    endtask

    task automatic drive(input bit [2:0] v);
        {vif.R_in, vif.G_in, vif.B_in} = v;
        rgb_h[n] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(3'b000);
        repeat (3) @(posedge vga_clk);
        #1 rst_n = 1'b1;
        n = 0;
        rgb_h.delete();
    endtask

    task automatic next();
        @(posedge vga_clk);
        #1 n++;
    endtask

    // Reference: coordinates are a plain function of cycles since release; pins show cycle n-2.
    function automatic logic [26:0] model(input int c);
        int x, y, cx, cy, m;
        logic hs, vs, de, rf;
        logic [2:0] rgb;
        x = c % HT;
        y = (c / HT) % VT;
        hs = 1'b1; vs = 1'b1; de = 1'b0; rgb = 3'b000; rf = 1'b0;
        if (c >= 2) begin
            cx = (c - 2) % HT;
            cy = ((c - 2) / HT) % VT;
            hs = !(cx < HS);
            vs = !(cy < VS);
            de = (cx >= HS + HB) && (cx < HS + HB + HA) && (cy >= VS + VB) && (cy < VS + VB + VA);
            rgb = de ? rgb_h[c - 1] : 3'b000;
        end
        if (c >= 1) begin
            m = c - 1;
            if (m % FRAME == TICK_OFF) rf = (((m / FRAME) + 1) % DIV) == 0;
        end
        return {10'(x), 10'(y), hs, vs, de, rgb, rf};
    endfunction

    initial begin
        int last_pulse, hs_lo, vs_lo, de_hi, prev_x, pulse_at;
        logic prev_de;

        tbl[0]  = '{0,   10'd0,  10'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1,   10'd1,  10'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{2,   10'd2,  10'd0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{5,   10'd5,  10'd0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{6,   10'd6,  10'd0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{17,  10'd0,  10'd1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{19,  10'd2,  10'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{36,  10'd2,  10'd2, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{76,  10'd8,  10'd4, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{77,  10'd9,  10'd4, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{84,  10'd16, 10'd4, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{85,  10'd0,  10'd5, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{169, 10'd16, 10'd9, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{172, 10'd2,  10'd0, 1'b0, 1'b0, 1'b0};

        {vif.R_in, vif.G_in, vif.B_in} = 3'b000;

        // Reset state while rst_n is held low
        rst_n = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        chk("reset_state", pins(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0});

        // Table vectors with colour held high: colour must follow de exactly
        do_reset();
        drive(3'b111);
        for (int i = 0; i < 14; i++) begin
            while (n < tbl[i].n) begin
                next();
                drive(3'b111);
            end
            @(negedge vga_clk);
            chk($sformatf("vec%0d", i), pins(),
                {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de, {3{tbl[i].de}}, 1'b0});
        end

        // Random colour against the reference model, over two refresh periods
        do_reset();
        last_pulse = -1; hs_lo = 0; vs_lo = 0; de_hi = 0;
        for (int i = 0; i < 2 * DIV * FRAME + 3 * FRAME; i++) begin
            if (i > 0) next();
            drive(3'($urandom_range(0, 7)));
            @(negedge vga_clk);
            chk("model", pins(), model(n));
            if (n >= 2 && n < 2 + FRAME) begin
                hs_lo += (vif.hsync == 1'b0);
                vs_lo += (vif.vsync == 1'b0);
                de_hi += (vif.de == 1'b1);
            end
            if (vif.refresh) begin
                if (last_pulse >= 0)
                    chk("refresh_period", 27'(n - last_pulse), 27'(DIV * FRAME));
                last_pulse = n;
            end
        end
        chk("hsync_low_per_frame", 27'(hs_lo), 27'(HS * VT));
        chk("vsync_low_per_frame", 27'(vs_lo), 27'(VS * HT));
        chk("de_high_per_frame",   27'(de_hi), 27'(HA * VA));

        // Renderer marks the first active column one cycle late; vga_r must rise with de
        do_reset();
        prev_x = 0; prev_de = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) next();
            drive({(prev_x == HS + HB), 2'b00});
            @(negedge vga_clk);
            chk("marker_r", {26'd0, vif.vga_r}, {26'd0, vif.de & ~prev_de});
            prev_x  = int'(vif.Xpos);
            prev_de = vif.de;
        end

        // Reset exactly at the tick point that would fire refresh
        do_reset();
        drive(3'b000);
        while (n < TICK_OFF + (DIV - 1) * FRAME) begin
            next();
            drive(3'b000);
        end
        rst_n = 1'b0;
        @(negedge vga_clk);
        chk("tick_position", {7'd0, vif.Xpos, vif.Ypos}, {7'd0, 10'd0, 10'(VS + VB + VA)});
        next();
        @(negedge vga_clk);
        chk("midframe_reset", pins(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0});
        next();
        @(negedge vga_clk);
        chk("midframe_reset_hold", {26'd0, vif.refresh}, 27'd0);
        @(posedge vga_clk);
        #1 rst_n = 1'b1;
        n = 0;
        pulse_at = -1;
        for (int i = 0; i < DIV * FRAME + 20 && pulse_at < 0; i++) begin
            if (i > 0) next();
            @(negedge vga_clk);
            if (vif.refresh) pulse_at = n;
        end
        chk("first_pulse_after_reset", 27'(pulse_at), 27'((DIV - 1) * FRAME + TICK_OFF + 1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
